// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory loads/stores over a req/ready handshake,
// stalls upstream while an access is outstanding and fills the MEM/WB register.
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            memrw_i,
    input  logic            regwen_i,
    input  logic [1:0]      wbsel_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            regwen_memwb,
    output logic [4:0]      rd_memwb,
    output logic [1:0]      wbsel_memwb,
    output logic [XLEN-1:0] wb_data_memwb,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam int CW = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            req_r, req_s;
    logic            we_r, we_s;
    logic [XLEN-1:0] addr_r, addr_s;
    logic [XLEN-1:0] wdata_r, wdata_s;
    logic            regwen_r, regwen_s;
    logic [4:0]      rd_r, rd_s;
    logic [1:0]      wbsel_r, wbsel_s;
    logic [XLEN-1:0] wbdata_r, wbdata_s;
    logic            misalign_r, misalign_s;
    logic            bus_err_r, bus_err_s;
    logic            stall_s;
    logic            is_load_s, is_mem_s, unaligned_s, cnt_last_s;
    logic [XLEN-1:0] sel_data_s;

    function automatic logic [XLEN-1:0] wb_select(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] mem_data,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] pc
    );
        logic [XLEN-1:0] res;
        case (sel)
            2'd0:    res = mem_data;
            2'd1:    res = alu;
            2'd2:    res = pc + XLEN'(4);
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    assign is_load_s   = ~memrw_i & regwen_i & (wbsel_i == 2'd0);
    assign is_mem_s    = memrw_i | is_load_s;
    assign unaligned_s = (alu_out_i[1:0] != 2'b00);
    assign cnt_last_s  = (cnt_r == CW'(MAX_WAIT - 1));
    assign sel_data_s  = wb_select(wbsel_i, dmem_rdata_i, alu_out_i, pc_i);

    // Next-state, next register values and the combinational stall
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        req_s      = req_r;
        we_s       = we_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        regwen_s   = 1'b0;
        rd_s       = 5'd0;
        wbsel_s    = 2'd0;
        wbdata_s   = {XLEN{1'b0}};
        misalign_s = 1'b0;
        bus_err_s  = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!is_mem_s) begin
                    regwen_s = regwen_i;
                    rd_s     = rd_i;
                    wbsel_s  = wbsel_i;
                    wbdata_s = sel_data_s;
                end else if (unaligned_s) begin
                    misalign_s = 1'b1;
                end else begin
                    stall_s = 1'b1;
                    state_s = ACCESS;
                    cnt_s   = {CW{1'b0}};
                    req_s   = 1'b1;
                    we_s    = memrw_i;
                    addr_s  = alu_out_i;
                    wdata_s = memrw_i ? rs2_i : {XLEN{1'b0}};
                end
            end
            ACCESS: begin
                stall_s = ~dmem_ready_i & ~cnt_last_s;
                if (dmem_ready_i) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    we_s    = 1'b0;
                    // a store only writes back when it also carries a register write
                    if (!memrw_i) begin
                        regwen_s = regwen_i;
                        rd_s     = rd_i;
                        wbsel_s  = wbsel_i;
                        wbdata_s = dmem_rdata_i;
                    end else if (regwen_i) begin
                        regwen_s = 1'b1;
                        rd_s     = rd_i;
                        wbsel_s  = wbsel_i;
                        wbdata_s = sel_data_s;
                    end else begin
                        regwen_s = 1'b0;
                    end
                end else if (cnt_last_s) begin
                    state_s   = IDLE;
                    req_s     = 1'b0;
                    we_s      = 1'b0;
                    bus_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
                we_s    = 1'b0;
            end
        endcase
    end

    // State and output registers, updated on the falling pipeline edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
            wdata_r    <= {XLEN{1'b0}};
            regwen_r   <= 1'b0;
            rd_r       <= 5'd0;
            wbsel_r    <= 2'd0;
            wbdata_r   <= {XLEN{1'b0}};
            misalign_r <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            req_r      <= req_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            regwen_r   <= regwen_s;
            rd_r       <= rd_s;
            wbsel_r    <= wbsel_s;
            wbdata_r   <= wbdata_s;
            misalign_r <= misalign_s;
            bus_err_r  <= bus_err_s;
        end
    end

    assign stall_o       = stall_s;
    assign dmem_req_o    = req_r;
    assign dmem_we_o     = we_r;
    assign dmem_addr_o   = addr_r;
    assign dmem_wdata_o  = wdata_r;
    assign regwen_memwb  = regwen_r;
    assign rd_memwb      = rd_r;
    assign wbsel_memwb   = wbsel_r;
    assign wb_data_memwb = wbdata_r;
    assign misalign_o    = misalign_r;
    assign bus_err_o     = bus_err_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Table-driven bench for mem_stage_ctrl (MAX_WAIT=4) plus a reset-during-access sequence.
module tb_mem_stage_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            memrw, regwen, ready;
    logic [1:0]      wbsel;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu, rs2, pc, rdata;
    logic            stall, req, we, regwen_wb, mis, berr;
    logic [XLEN-1:0] addr, wdata, wb_data;
    logic [4:0]      rd_wb;
    logic [1:0]      wbsel_wb;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.MAX_WAIT(4), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .memrw_i(memrw), .regwen_i(regwen), .wbsel_i(wbsel),
        .rd_i(rd), .alu_out_i(alu), .rs2_i(rs2), .pc_i(pc), .stall_o(stall),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
        .dmem_ready_i(ready), .dmem_rdata_i(rdata), .regwen_memwb(regwen_wb),
        .rd_memwb(rd_wb), .wbsel_memwb(wbsel_wb), .wb_data_memwb(wb_data),
        .misalign_o(mis), .bus_err_o(berr)
    );

    typedef struct {
        logic        memrw, regwen;
        logic [1:0]  wbsel;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, pc;
        logic        ready;
        logic [31:0] rdata;
        logic        e_stall, e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_regwen;
        logic [4:0]  e_rd;
        logic [31:0] e_wb;
        logic        e_mis, e_berr;
    } vec_t;

    vec_t vecs[$];
    int tests = 0;
    int failed = 0;

    function automatic vec_t mk(
        input logic m, input logic rw, input logic [1:0] ws, input logic [4:0] r,
        input logic [31:0] a, input logic [31:0] s2, input logic [31:0] p,
        input logic rdy, input logic [31:0] rdat,
        input logic es, input logic erq, input logic ewe, input logic [31:0] ead,
        input logic [31:0] ewd, input logic erw, input logic [4:0] erd,
        input logic [31:0] ewb, input logic emis, input logic eberr);
        vec_t v;
        v.memrw = m; v.regwen = rw; v.wbsel = ws; v.rd = r; v.alu = a; v.rs2 = s2; v.pc = p;
        v.ready = rdy; v.rdata = rdat; v.e_stall = es; v.e_req = erq; v.e_we = ewe;
        v.e_addr = ead; v.e_wdata = ewd; v.e_regwen = erw; v.e_rd = erd; v.e_wb = ewb;
        v.e_mis = emis; v.e_berr = eberr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic rw, input logic [1:0] ws, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] s2, input logic [31:0] p,
                         input logic rdy, input logic [31:0] rdat);
        memrw = m; regwen = rw; wbsel = ws; rd = r; alu = a; rs2 = s2; pc = p;
        ready = rdy; rdata = rdat;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(req), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_addr"}, addr, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_regwen"}, 32'(regwen_wb), 32'd0);
        chk({tag, "_rd"}, 32'(rd_wb), 32'd0);
        chk({tag, "_wbsel"}, 32'(wbsel_wb), 32'd0);
        chk({tag, "_wb"}, wb_data, 32'd0);
        chk({tag, "_mis"}, 32'(mis), 32'd0);
        chk({tag, "_berr"}, 32'(berr), 32'd0);
    endtask

    initial begin
        //                 m     rw    ws    rd     alu           rs2           pc            rdy   rdata
        //                 stall req   we    addr          wdata         regwen rd    wb            mis   berr
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0));
        // load 0x100, ready on the third access edge
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd7, 32'h100, 32'h55, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd7, 32'h100, 32'h55, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd7, 32'h100, 32'h55, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd7, 32'h100, 32'h55, 32'h0, 1'b1, 32'hDEADBEEF,
                          1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0));
        // store 0x200, ready on the first access edge
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 5'd0, 32'h200, 32'hCAFE, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b1, 32'h200, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 5'd0, 32'h200, 32'hCAFE, 32'h0, 1'b1, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h200, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        // ready is ignored in IDLE
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 5'd3, 32'h7, 32'h0, 32'h1000, 1'b1, 32'h77,
                          1'b0, 1'b0, 1'b0, 32'h200, 32'hCAFE, 1'b1, 5'd3, 32'h1004, 1'b0, 1'b0));
        // timeout: four access edges without ready
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd9, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd9, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0,
                              1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd9, 32'h300, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1));
        // misaligned load, then JAL
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd4, 32'h102, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 5'd1, 32'h999, 32'h0, 32'h40, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 5'd1, 32'h44, 1'b0, 1'b0));
        // store that also writes a register, then back-to-back load
        vecs.push_back(mk(1'b1, 1'b1, 2'd1, 5'd2, 32'h10, 32'hAB, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b1, 32'h10, 32'hAB, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'd1, 5'd2, 32'h10, 32'hAB, 32'h0, 1'b1, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h10, 32'hAB, 1'b1, 5'd2, 32'h10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd6, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'd6, 32'h20, 32'h0, 32'h0, 1'b1, 32'h12345678,
                          1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 5'd6, 32'h12345678, 1'b0, 1'b0));
        // reserved select, pc+4 wrap, misaligned store
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 5'd8, 32'h5, 32'h0, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 5'd8, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 5'd9, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 5'd9, 32'h2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 5'd0, 32'h3, 32'h11, 32'h0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0));

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].memrw, vecs[i].regwen, vecs[i].wbsel, vecs[i].rd, vecs[i].alu,
                  vecs[i].rs2, vecs[i].pc, vecs[i].ready, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            chk($sformatf("v%0d_req", i), 32'(req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_regwen", i), 32'(regwen_wb), 32'(vecs[i].e_regwen));
            chk($sformatf("v%0d_rd", i), 32'(rd_wb), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_wb", i), wb_data, vecs[i].e_wb);
            chk($sformatf("v%0d_mis", i), 32'(mis), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d_berr", i), 32'(berr), 32'(vecs[i].e_berr));
        end

        // reset asserted mid-access drops the request at once
        drive(1'b0, 1'b1, 2'd0, 5'd5, 32'h400, 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        chk("rst_pre_req", 32'(req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 2'd1, 5'd11, 32'h55, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rst_post_stall", 32'(stall), 32'd0);
        @(posedge clk);
        chk("rst_post_regwen", 32'(regwen_wb), 32'd1);
        chk("rst_post_rd", 32'(rd_wb), 32'd11);
        chk("rst_post_wb", wb_data, 32'h55);
        chk("rst_post_req", 32'(req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs data-memory loads and stores over a req/ready handshake.
- Stalls the upstream pipeline while an access is outstanding, then writes the MEM/WB register including the selected write-back data.
- Traps misaligned and timed-out accesses as bubbles with one-cycle error pulses.

Parameters:
MAX_WAIT, 16, maximum ACCESS-state edges waited for dmem_ready_i before abort (range 2..255)
XLEN, 32, datapath width

Ports:
clk  input  1  pipeline clock; all state updates on negedge clk
rst_n  input  1  reset, asynchronous, active-low
memrw_i  input  1  1 = store (from EX/MEM)
regwen_i  input  1  register write enable (from EX/MEM)
wbsel_i  input  2  write-back select: 0 mem, 1 alu, 2 pc+4, 3 reserved
rd_i  input  5  destination register
alu_out_i  input  XLEN  ALU result / memory address
rs2_i  input  XLEN  store data
pc_i  input  XLEN  instruction PC
stall_o  output  1  combinational; 1 = upstream must hold EX/MEM contents
dmem_req_o  output  1  registered access request
dmem_we_o  output  1  registered write strobe
dmem_addr_o  output  XLEN  registered word address
dmem_wdata_o  output  XLEN  registered store data
dmem_ready_i  input  1  memory completion; sampled on negedge
dmem_rdata_i  input  XLEN  load data, valid with dmem_ready_i
regwen_memwb  output  1  MEM/WB write enable
rd_memwb  output  5  MEM/WB destination
wbsel_memwb  output  2  MEM/WB select (debug/forwarding)
wb_data_memwb  output  XLEN  MEM/WB write-back value
misalign_o  output  1  one-cycle pulse, misaligned access dropped
bus_err_o  output  1  one-cycle pulse, access timed out

Behaviour:
- Reset (async): state=IDLE, wait counter 0. Every registered output is 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, all *_memwb, misalign_o, bus_err_o.
- Reset during ACCESS drops dmem_req_o immediately; no MEM/WB update.
- Access types:
  - store: memrw_i=1.
  - load: memrw_i=0, regwen_i=1, wbsel_i=0.
  - Anything else is a non-memory op.
- Write-back select: 0 -> load data; 1 -> alu_out_i; 2 -> pc_i+4 (mod 2^XLEN); 3 -> 0.
- IDLE, non-memory op:
  - stall_o=0.
  - Next edge loads MEM/WB: regwen, rd, wbsel, selected data. Latency 1 edge.
- IDLE, memory op, alu_out_i[1:0]!=0:
  - stall_o=0, no request.
  - Next edge: MEM/WB bubble (regwen=0, rd=0, data=0), misalign_o=1 for one cycle.
- IDLE, aligned memory op:
  - stall_o=1 combinationally.
  - Next edge: state=ACCESS; dmem_req_o=1; dmem_we_o=memrw_i; dmem_addr_o=alu_out_i; dmem_wdata_o=rs2_i (0 for loads); MEM/WB bubble; counter=0.
- ACCESS:
  - stall_o = ~dmem_ready_i & ~(counter==MAX_WAIT-1).
  - On an edge with dmem_ready_i=1: MEM/WB loaded from the held inputs; a load takes wb_data=dmem_rdata_i, a store writes a bubble unless regwen_i (then the selected data). Also dmem_req_o=0, dmem_we_o=0, state=IDLE.
  - Else, counter==MAX_WAIT-1: abort; dmem_req_o=0; MEM/WB bubble; bus_err_o=1 for one cycle; state=IDLE.
  - Else counter++.
- Every access occupies at least 2 edges. A back-to-back memory op re-enters ACCESS from IDLE; no request overlap.
- dmem_ready_i is ignored in IDLE.
- Request address/data are held stable throughout ACCESS.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS -> dmem_req_o=0 immediately, all outputs 0, state IDLE after release.
- ALU op: regwen=1, wbsel=1, rd=5, alu=0x1234 -> next edge regwen_memwb=1, rd_memwb=5, wb_data_memwb=0x1234, stall_o never 1.
- Load: addr 0x100, ready asserted on the 3rd ACCESS edge with rdata=0xDEADBEEF -> stall_o high 3 cycles, req stable, then wb_data_memwb=0xDEADBEEF, rd correct, bubbles before.
- Store: memrw=1, addr 0x200, rs2=0xCAFE, ready on the first ACCESS edge -> dmem_we_o=1, wdata=0xCAFE, regwen_memwb=0, stall released after 1 cycle.
- Timeout: MAX_WAIT=4, ready held 0 -> req drops after 4 ACCESS edges, bus_err_o pulses once, MEM/WB bubble, stall_o released.
- Misaligned load addr 0x102, then JAL with wbsel=2, pc=0x40 -> misalign_o pulse, no req, bubble; next op wb_data_memwb=0x44.
